// File: rtl/eth_frame_gen_pkg.sv
// Shared types, sizes and length-clamping helper for the Ethernet test-frame generator.
package eth_frame_gen_pkg;

  localparam int N_SYMBOLS     = 8;
  localparam int W_SYMBOL      = 8;
  localparam int DATA_W        = N_SYMBOLS * W_SYMBOL;
  localparam int MIN_FRAME_LEN = 60;
  localparam int MAX_FRAME_LEN = 1514;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } gen_state_t;

  function automatic logic [10:0] clamp_frame_len(input logic [15:0] len);
    if (len < 16'(MIN_FRAME_LEN)) return 11'(MIN_FRAME_LEN);
    if (len > 16'(MAX_FRAME_LEN)) return 11'(MAX_FRAME_LEN);
    return len[10:0];
  endfunction

endpackage

// File: rtl/eth_frame_gen_if.sv
// AXI-Stream byte-lane bus carrying generated frames toward the MAC.
interface eth_frame_gen_if;
  import eth_frame_gen_pkg::*;

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [N_SYMBOLS-1:0] tkeep;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/eth_gen_beat_builder.sv
// Combinational builder of one 8-byte beat from (beat index, sequence number, frame length).
module eth_gen_beat_builder
  import eth_frame_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [7:0]           beat_idx,
  input  logic [31:0]          seq,
  input  logic [10:0]          frame_len,
  output logic [DATA_W-1:0]    tdata,
  output logic [N_SYMBOLS-1:0] tkeep,
  output logic                 tlast
);
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  logic [7:0] n_beats;
  logic [2:0] tail;

  assign n_beats = 8'((frame_len + 11'd7) >> 3);
  assign tail    = frame_len[2:0];
  assign tlast   = (beat_idx == n_beats - 8'd1);
  assign tkeep   = (tlast && tail != 3'd0) ? (8'hFF >> (4'd8 - {1'b0, tail})) : 8'hFF;

  for (genvar gi = 0; gi < N_SYMBOLS; gi++) begin : g_sym
    logic [10:0] k;
    logic [3:0]  hdr_sel;
    logic [1:0]  seq_sel;
    logic [7:0]  sym;

    assign k       = {beat_idx, 3'(gi)};
    assign hdr_sel = 4'd13 - k[3:0];
    assign seq_sel = 2'd3 - 2'(k - 11'd14);

    // Header and sequence number go out most-significant byte first.
    always_comb begin
      if (k < 11'd14)      sym = HDR[{hdr_sel, 3'b000} +: 8];
      else if (k < 11'd18) sym = seq[{seq_sel, 3'b000} +: 8];
      else                 sym = k[7:0];
    end

    assign tdata[gi*W_SYMBOL +: W_SYMBOL] = tkeep[gi] ? sym : 8'h00;
  end
endmodule

// File: rtl/eth_frame_gen.sv
// Test-frame transmitter: programmable length, gap and count, with sequence-numbered payload.
module eth_frame_gen
  import eth_frame_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic [15:0]     i_frame_len,
  input  logic [7:0]      i_ifg_cycles,
  input  logic [15:0]     i_num_frames,
  eth_frame_gen_if.master m_axis,
  output logic            o_busy,
  output logic            o_done,
  output logic [31:0]     o_frame_cnt
);
  gen_state_t           state_reg;
  logic                 tvalid_reg, tlast_reg, busy_reg, done_reg;
  logic                 stop_pending_reg, continuous_reg;
  logic [DATA_W-1:0]    tdata_reg;
  logic [N_SYMBOLS-1:0] tkeep_reg;
  logic [7:0]           beat_idx_reg, ifg_reg, gap_cnt_reg;
  logic [10:0]          len_reg;
  logic [31:0]          seq_reg, frame_cnt_reg;
  logic [15:0]          remaining_reg;

  logic                 fire, stop_now, run_ends, load_frame;
  logic [10:0]          len_clamped, bb_len;
  logic [31:0]          frame_cnt_inc, bb_seq;
  logic [7:0]           bb_idx;
  logic [DATA_W-1:0]    bb_tdata;
  logic [N_SYMBOLS-1:0] bb_tkeep;
  logic                 bb_tlast;

  assign fire          = tvalid_reg & m_axis.tready;
  assign stop_now      = stop_pending_reg | i_stop;
  assign run_ends      = stop_now | (~continuous_reg & (remaining_reg == 16'd1));
  assign len_clamped   = clamp_frame_len(i_frame_len);
  assign frame_cnt_inc = frame_cnt_reg + 32'd1;

  // A new frame's first beat is loaded in the same edge that leaves IDLE, GAP or the previous tlast.
  always_comb begin
    load_frame = 1'b0;
    case (state_reg)
      IDLE:    load_frame = i_start & ~i_stop;
      SEND:    load_frame = fire & tlast_reg & ~run_ends & (ifg_reg == 8'd0);
      GAP:     load_frame = (gap_cnt_reg == 8'd1) & ~stop_now;
      default: load_frame = 1'b0;
    endcase
  end

  assign bb_idx = load_frame ? 8'd0 : beat_idx_reg + 8'd1;
  assign bb_len = load_frame ? len_clamped : len_reg;
  assign bb_seq = !load_frame ? seq_reg :
                  (state_reg == SEND) ? frame_cnt_inc : frame_cnt_reg;

  eth_gen_beat_builder #(
    .DST_MAC  (DST_MAC),
    .SRC_MAC  (SRC_MAC),
    .ETHERTYPE(ETHERTYPE)
  ) u_beat_builder (
    .beat_idx (bb_idx),
    .seq      (bb_seq),
    .frame_len(bb_len),
    .tdata    (bb_tdata),
    .tkeep    (bb_tkeep),
    .tlast    (bb_tlast)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg        <= IDLE;
      tvalid_reg       <= 1'b0;
      tlast_reg        <= 1'b0;
      tdata_reg        <= '0;
      tkeep_reg        <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      stop_pending_reg <= 1'b0;
      continuous_reg   <= 1'b0;
      beat_idx_reg     <= 8'd0;
      ifg_reg          <= 8'd0;
      gap_cnt_reg      <= 8'd0;
      len_reg          <= 11'd0;
      seq_reg          <= 32'd0;
      frame_cnt_reg    <= 32'd0;
      remaining_reg    <= 16'd0;
    end else begin
      done_reg <= 1'b0;
      if (load_frame || (state_reg == SEND && fire && !tlast_reg)) begin
        tvalid_reg   <= 1'b1;
        tdata_reg    <= bb_tdata;
        tkeep_reg    <= bb_tkeep;
        tlast_reg    <= bb_tlast;
        beat_idx_reg <= bb_idx;
        seq_reg      <= bb_seq;
        len_reg      <= bb_len;
      end
      if (load_frame) begin
        ifg_reg   <= i_ifg_cycles;
        state_reg <= SEND;
        busy_reg  <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (load_frame) begin
            remaining_reg  <= i_num_frames;
            continuous_reg <= (i_num_frames == 16'd0);
          end
        end
        SEND: begin
          if (i_stop) stop_pending_reg <= 1'b1;
          if (fire && tlast_reg) begin
            frame_cnt_reg <= frame_cnt_inc;
            if (!continuous_reg) remaining_reg <= remaining_reg - 16'd1;
            if (run_ends) begin
              tvalid_reg       <= 1'b0;
              tlast_reg        <= 1'b0;
              state_reg        <= IDLE;
              busy_reg         <= 1'b0;
              done_reg         <= 1'b1;
              stop_pending_reg <= 1'b0;
            end else if (ifg_reg != 8'd0) begin
              tvalid_reg  <= 1'b0;
              tlast_reg   <= 1'b0;
              gap_cnt_reg <= ifg_reg;
              state_reg   <= GAP;
            end
          end
        end
        GAP: begin
          if (i_stop) stop_pending_reg <= 1'b1;
          if (gap_cnt_reg == 8'd1) begin
            if (stop_now) begin
              state_reg        <= IDLE;
              busy_reg         <= 1'b0;
              done_reg         <= 1'b1;
              stop_pending_reg <= 1'b0;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tkeep  = tkeep_reg;
  assign m_axis.tlast  = tlast_reg;
  assign o_busy        = busy_reg;
  assign o_done        = done_reg;
  assign o_frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: byte-level frame model, per-cycle bus compare, directed scenarios.
module tb_eth_frame_gen;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] i_frame_len = 16'd60;
  logic [7:0]  i_ifg_cycles = 8'd0;
  logic [15:0] i_num_frames = 16'd1;
  logic        o_busy, o_done;
  logic [31:0] o_frame_cnt;

  eth_frame_gen_if axis();

  eth_frame_gen dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_frame_len (i_frame_len),
    .i_ifg_cycles(i_ifg_cycles),
    .i_num_frames(i_num_frames),
    .m_axis      (axis),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_frame_cnt (o_frame_cnt)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        first;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  int          hs_count = 0;
  int          stalls_seen = 0;
  int          exp_gap = -1;
  int          idle_run = 0;
  int          beats_in_frame = 0;
  int          frame_beats_seen = 0;
  int          frames_seen = 0;
  logic        after_tlast = 1'b0;
  logic        stall_prev = 1'b0;
  logic        rand_ready = 1'b0;
  logic [63:0] held_data;
  logic [7:0]  held_keep;
  logic        held_last;
  logic [7:0]  last_keep_seen = 8'h00;
  logic [63:0] last_data_seen = 64'd0;

  // Frame contents straight from the byte-layout rules: header, big-endian sequence, k mod 256.
  function automatic logic [7:0] frame_byte(input int k, input logic [31:0] seq);
    logic [111:0] hdr;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
    if (k < 14) return hdr[8*(13-k) +: 8];
    if (k < 18) return seq[8*(17-k) +: 8];
    return 8'(k % 256);
  endfunction

  task automatic push_frame(input int len, input int seq);
    int    flen;
    int    nb;
    beat_t e;
    flen = (len < 60) ? 60 : ((len > 1514) ? 1514 : len);
    nb   = (flen + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e.data  = 64'd0;
      e.keep  = 8'h00;
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < flen) begin
          e.data[8*j +: 8] = frame_byte(b * 8 + j, 32'(seq));
          e.keep[j] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    for (int c = 0; c < budget && done_count == d0; c++) tick();
    check({name, "_done_seen"}, 64'(done_count - d0), 64'd1);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frames(input int len, input int ifg, input int num, input int seq0,
                            input string name);
    int d0;
    for (int f = 0; f < num; f++) push_frame(len, seq0 + f);
    i_frame_len  = 16'(len);
    i_ifg_cycles = 8'(ifg);
    i_num_frames = 16'(num);
    d0 = done_count;
    pulse_start();
    check({name, "_start_latency_tvalid"}, 64'(axis.tvalid), 64'd1);
    wait_done(d0, 4000, name);
  endtask

  always @(posedge i_clk) begin
    #1;
    axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Single compare process: every beat presented with tready is checked against the model.
  always @(negedge i_clk) begin
    beat_t e;
    if (!i_reset_n) begin
      stall_prev  = 1'b0;
      after_tlast = 1'b0;
      idle_run    = 0;
    end else begin
      if (o_done) done_count++;
      if (stall_prev) begin
        checks++;
        if (!axis.tvalid || axis.tdata !== held_data || axis.tkeep !== held_keep ||
            axis.tlast !== held_last) begin
          failures++;
          $display("FAIL stall_stable: got v=%b d=%h k=%h l=%b required v=1 d=%h k=%h l=%b",
                   axis.tvalid, axis.tdata, axis.tkeep, axis.tlast, held_data, held_keep, held_last);
        end
      end
      if (axis.tvalid && axis.tready) begin
        hs_count++;
        stall_prev = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got d=%h k=%h l=%b required no beat",
                   axis.tdata, axis.tkeep, axis.tlast);
        end else begin
          e = exp_q.pop_front();
          if ((axis.tdata & {{8{e.keep[7]}}, {8{e.keep[6]}}, {8{e.keep[5]}}, {8{e.keep[4]}},
                             {8{e.keep[3]}}, {8{e.keep[2]}}, {8{e.keep[1]}}, {8{e.keep[0]}}})
                  !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
            failures++;
            $display("FAIL beat: got d=%h k=%h l=%b required d=%h k=%h l=%b",
                     axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
          end
          if (e.first && after_tlast && exp_gap >= 0) begin
            checks++;
            if (idle_run != exp_gap) begin
              failures++;
              $display("FAIL ifg_cycles: got %0d required %0d", idle_run, exp_gap);
            end
          end
          if (e.first) after_tlast = 1'b0;
          beats_in_frame = e.first ? 1 : beats_in_frame + 1;
        end
        if (axis.tlast) begin
          after_tlast      = 1'b1;
          idle_run         = 0;
          frame_beats_seen = beats_in_frame;
          last_keep_seen   = axis.tkeep;
          last_data_seen   = axis.tdata;
          frames_seen++;
          $display("frame %0d: beats=%0d last_keep=%h", frames_seen, beats_in_frame, axis.tkeep);
        end
      end else begin
        if (!axis.tvalid) idle_run++;
        else stalls_seen++;
        stall_prev = axis.tvalid;
        held_data  = axis.tdata;
        held_keep  = axis.tkeep;
        held_last  = axis.tlast;
      end
    end
  end

  initial begin
    int d0;
    int hs0;
    axis.tready = 1'b1;
    do_reset();

    check("reset_tvalid", 64'(axis.tvalid), 64'd0);
    check("reset_tlast", 64'(axis.tlast), 64'd0);
    check("reset_tdata", axis.tdata, 64'd0);
    check("reset_tkeep", 64'(axis.tkeep), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_frame_cnt", 64'(o_frame_cnt), 64'd0);

    // Minimum frame, one shot.
    run_frames(60, 0, 1, 0, "len60");
    check("len60_beats", 64'(frame_beats_seen), 64'd8);
    check("len60_last_keep", 64'(last_keep_seen), 64'h0F);
    check("len60_frame_cnt", 64'(o_frame_cnt), 64'd1);
    check("len60_busy_after", 64'(o_busy), 64'd0);

    // Backpressure on a 64-byte frame.
    rand_ready = 1'b1;
    run_frames(64, 0, 1, 1, "len64_bp");
    rand_ready = 1'b0;
    check("len64_beats", 64'(frame_beats_seen), 64'd8);
    check("len64_last_keep", 64'(last_keep_seen), 64'hFF);
    check("len64_byte63", 64'(last_data_seen[63:56]), 64'h3F);
    check("len64_stalls_seen", 64'(stalls_seen > 0), 64'd1);

    // Clamping at both ends.
    run_frames(10, 0, 1, 2, "len10");
    check("len10_beats", 64'(frame_beats_seen), 64'd8);
    run_frames(2000, 0, 1, 3, "len2000");
    check("len2000_beats", 64'(frame_beats_seen), 64'd190);
    check("len2000_last_keep", 64'(last_keep_seen), 64'h03);
    check("len2000_frame_cnt", 64'(o_frame_cnt), 64'd4);

    // Counted run with gaps.
    do_reset();
    exp_gap = 3;
    run_frames(60, 3, 3, 0, "count3_ifg3");
    check("count3_frame_cnt", 64'(o_frame_cnt), 64'd3);

    // Continuous run stopped mid-frame; no bubbles between back-to-back frames.
    do_reset();
    exp_gap = 0;
    for (int f = 0; f < 3; f++) push_frame(60, f);
    i_frame_len  = 16'd60;
    i_ifg_cycles = 8'd0;
    i_num_frames = 16'd0;
    d0  = done_count;
    hs0 = hs_count;
    pulse_start();
    for (int c = 0; c < 200 && hs_count < hs0 + 20; c++) tick();
    check("cont_reached_frame2_beat4", 64'(hs_count - hs0), 64'd20);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("cont_busy_after_stop", 64'(o_busy), 64'd1);
    wait_done(d0, 200, "cont_stop");
    check("cont_frame_cnt", 64'(o_frame_cnt), 64'd3);
    exp_gap = -1;

    // Start and stop together in IDLE.
    d0 = done_count;
    i_start = 1'b1;
    i_stop  = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop  = 1'b0;
    repeat (20) tick();
    check("start_stop_busy", 64'(o_busy), 64'd0);
    check("start_stop_tvalid", 64'(axis.tvalid), 64'd0);
    check("start_stop_no_done", 64'(done_count - d0), 64'd0);
    check("start_stop_frame_cnt", 64'(o_frame_cnt), 64'd3);

    // Asynchronous reset in the middle of a frame.
    push_frame(200, 3);
    i_frame_len  = 16'd200;
    i_num_frames = 16'd1;
    hs0 = hs_count;
    pulse_start();
    for (int c = 0; c < 100 && hs_count < hs0 + 5; c++) tick();
    check("async_reached_beat5", 64'(hs_count - hs0), 64'd5);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    check("async_tvalid_now", 64'(axis.tvalid), 64'd0);
    check("async_busy_now", 64'(o_busy), 64'd0);
    exp_q.delete();
    tick();
    tick();
    i_reset_n = 1'b1;
    repeat (20) tick();
    check("post_reset_tvalid", 64'(axis.tvalid), 64'd0);
    check("post_reset_busy", 64'(o_busy), 64'd0);
    check("post_reset_frame_cnt", 64'(o_frame_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
